// File: rtl/regfile_sb.sv
// Integer register file (2 combinational read ports, 1 write port) with a
// write-pending scoreboard that tracks outstanding producers per register.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREG),
    localparam int unsigned CW      = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra0,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] do0,
    output logic [XLEN-1:0] do1,
    output logic            busy0,
    output logic            busy1,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [CW-1:0]   pend_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CW-1:0]   pend_q;
    logic [CW-1:0]   pend_d;
    logic            wr_en;

    // Register 0 is hardwired when ZERO_REG is set, so its writes are dropped.
    assign wr_en = we && !(ZERO_REG && (wa == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[AW'(i)] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    function automatic logic [XLEN-1:0] rd_mux(
        input logic [AW-1:0]   ra,
        input logic [XLEN-1:0] rq,
        input logic            we_v,
        input logic [AW-1:0]   wa_v,
        input logic [XLEN-1:0] wd_v
    );
        if (ZERO_REG && (ra == '0)) begin
            return '0;
        end else if (BYPASS && we_v && (wa_v == ra)) begin
            return wd_v;
        end else begin
            return rq;
        end
    endfunction

    assign do0 = rd_mux(ra0, regs_q[ra0], we, wa, wd);
    assign do1 = rd_mux(ra1, regs_q[ra1], we, wa, wd);

    // A register whose value is being forwarded this cycle is no longer a hazard.
    assign busy0 = busy_q[ra0] && !(BYPASS && we && (wa == ra0));
    assign busy1 = busy_q[ra1] && !(BYPASS && we && (wa == ra1));

    // Scoreboard update: flush beats everything, a new issue beats an older writeback.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (we) begin
                busy_d[wa] = 1'b0;
            end
            if (iss_v) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        pend_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            pend_d = pend_d + CW'(busy_d[AW'(i)]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign pend_cnt = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default configuration (a_*) and a
// 64-bit, 16-entry, no-zero-reg, no-bypass configuration (b_*).
module tb_regfile_sb;

    logic clk;
    logic rst;

    logic [4:0]  a_ra0, a_ra1, a_wa, a_iss_rd;
    logic [31:0] a_do0, a_do1, a_wd;
    logic        a_busy0, a_busy1, a_we, a_iss_v, a_flush;
    logic [5:0]  a_pend;

    logic [3:0]  b_ra0, b_ra1, b_wa, b_iss_rd;
    logic [63:0] b_do0, b_do1, b_wd;
    logic        b_busy0, b_busy1, b_we, b_iss_v, b_flush;
    logic [4:0]  b_pend;

    int n_cmp;
    int n_bad;

    regfile_sb u_a (
        .clk(clk), .rst(rst),
        .ra0(a_ra0), .ra1(a_ra1), .do0(a_do0), .do1(a_do1),
        .busy0(a_busy0), .busy1(a_busy1),
        .we(a_we), .wa(a_wa), .wd(a_wd),
        .iss_v(a_iss_v), .iss_rd(a_iss_rd), .flush(a_flush),
        .pend_cnt(a_pend)
    );

    regfile_sb #(.XLEN(64), .NREG(16), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .ra0(b_ra0), .ra1(b_ra1), .do0(b_do0), .do1(b_do1),
        .busy0(b_busy0), .busy1(b_busy1),
        .we(b_we), .wa(b_wa), .wd(b_wd),
        .iss_v(b_iss_v), .iss_rd(b_iss_rd), .flush(b_flush),
        .pend_cnt(b_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_we = 1'b0; a_wa = '0; a_wd = '0;
        a_iss_v = 1'b0; a_iss_rd = '0; a_flush = 1'b0;
    endtask

    task automatic idle_b();
        b_we = 1'b0; b_wa = '0; b_wd = '0;
        b_iss_v = 1'b0; b_iss_rd = '0; b_flush = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        idle_a(); idle_b();
        a_ra0 = 5'd5; a_ra1 = 5'd3; b_ra0 = '0; b_ra1 = '0;
        #12;
        chk("rst_do0", 64'(a_do0), 64'h0);
        chk("rst_busy0", 64'(a_busy0), 64'h0);
        chk("rst_pend", 64'(a_pend), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Write reg 5, bypass same cycle, then array readback on both ports
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; a_ra0 = 5'd5; a_ra1 = 5'd3;
        #1;
        chk("bypass_do0", 64'(a_do0), 64'hDEADBEEF);
        chk("bypass_other_do1", 64'(a_do1), 64'h0);
        step();
        idle_a(); a_ra1 = 5'd5;
        #1;
        chk("rd_do0", 64'(a_do0), 64'hDEADBEEF);
        chk("rd_do1", 64'(a_do1), 64'hDEADBEEF);

        // x0: writes and issues are ignored
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'h1234;
        a_iss_v = 1'b1; a_iss_rd = 5'd0; a_ra0 = 5'd0;
        #1;
        chk("x0_bypass_do0", 64'(a_do0), 64'h0);
        chk("x0_busy0_same", 64'(a_busy0), 64'h0);
        step();
        idle_a();
        #1;
        chk("x0_do0", 64'(a_do0), 64'h0);
        chk("x0_busy0", 64'(a_busy0), 64'h0);
        chk("x0_pend", 64'(a_pend), 64'h0);

        // Scoreboard: issue 3 and 7
        a_iss_v = 1'b1; a_iss_rd = 5'd3;
        step();
        a_iss_rd = 5'd7;
        step();
        idle_a(); a_ra0 = 5'd3; a_ra1 = 5'd7;
        #1;
        chk("sb_pend2", 64'(a_pend), 64'd2);
        chk("sb_busy3", 64'(a_busy0), 64'h1);
        chk("sb_busy7", 64'(a_busy1), 64'h1);
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h0000AAAA;
        #1;
        chk("sb_busy3_fwd", 64'(a_busy0), 64'h0);
        chk("sb_do0_fwd", 64'(a_do0), 64'h0000AAAA);
        chk("sb_busy7_hold", 64'(a_busy1), 64'h1);
        step();
        idle_a();
        #1;
        chk("sb_busy3_clr", 64'(a_busy0), 64'h0);
        chk("sb_pend1", 64'(a_pend), 64'd1);
        chk("sb_do0_arr", 64'(a_do0), 64'h0000AAAA);

        // Same-cycle issue + writeback to 7: new producer wins
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h77; a_iss_v = 1'b1; a_iss_rd = 5'd7;
        #1;
        chk("sb_busy7_fwd", 64'(a_busy1), 64'h0);
        step();
        idle_a();
        #1;
        chk("sb_busy7_win", 64'(a_busy1), 64'h1);
        chk("sb_pend_win", 64'(a_pend), 64'd1);
        chk("sb_do1_77", 64'(a_do1), 64'h77);

        // Re-issue to busy reg; writeback to non-busy reg
        a_iss_v = 1'b1; a_iss_rd = 5'd7;
        step();
        idle_a();
        a_we = 1'b1; a_wa = 5'd4; a_wd = 32'h44;
        step();
        idle_a(); a_ra0 = 5'd4;
        #1;
        chk("sb_reissue_pend", 64'(a_pend), 64'd1);
        chk("sb_nb_busy4", 64'(a_busy0), 64'h0);
        chk("sb_nb_do4", 64'(a_do0), 64'h44);

        // Issue without forwarding is not visible until the next edge
        a_iss_v = 1'b1; a_iss_rd = 5'd9; a_ra0 = 5'd9;
        #1;
        chk("iss_no_force", 64'(a_busy0), 64'h0);
        step();
        a_iss_rd = 5'd11;
        step();
        a_iss_rd = 5'd12;
        step();
        idle_a();
        #1;
        chk("fl_pend4", 64'(a_pend), 64'd4);
        chk("fl_busy9", 64'(a_busy0), 64'h1);

        // Flush beats a same-cycle issue
        a_flush = 1'b1; a_iss_v = 1'b1; a_iss_rd = 5'd9;
        step();
        idle_a(); a_ra0 = 5'd9; a_ra1 = 5'd7;
        #1;
        chk("fl_pend0", 64'(a_pend), 64'd0);
        chk("fl_busy9_clr", 64'(a_busy0), 64'h0);
        chk("fl_busy7_clr", 64'(a_busy1), 64'h0);

        // Asynchronous reset mid-run
        a_iss_v = 1'b1; a_iss_rd = 5'd2;
        step();
        idle_a(); a_ra0 = 5'd5; a_ra1 = 5'd2;
        #1;
        chk("mr_pre_pend", 64'(a_pend), 64'd1);
        chk("mr_pre_do0", 64'(a_do0), 64'hDEADBEEF);
        rst = 1'b0;
        #1;
        chk("mr_do0", 64'(a_do0), 64'h0);
        chk("mr_busy1", 64'(a_busy1), 64'h0);
        chk("mr_pend", 64'(a_pend), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Second configuration: reg 0 is ordinary, no forwarding
        b_we = 1'b1; b_wa = 4'd0; b_wd = 64'h1; b_ra0 = 4'd0;
        #1;
        chk("b_nobypass_do0", b_do0, 64'h0);
        step();
        idle_b();
        #1;
        chk("b_reg0_do0", b_do0, 64'h1);

        for (int i = 0; i < 16; i++) begin
            b_we = 1'b1; b_wa = 4'(i); b_wd = {32'hC0DE0000 | 32'(i), ~32'(i)};
            step();
        end
        idle_b();
        for (int i = 0; i < 16; i++) begin
            b_ra0 = 4'(i); b_ra1 = 4'(15 - i);
            #1;
            chk("b_all_do0", b_do0, {32'hC0DE0000 | 32'(i), ~32'(i)});
            chk("b_all_do1", b_do1, {32'hC0DE0000 | 32'(15 - i), ~32'(15 - i)});
        end

        // Fill the scoreboard to its upper bound
        for (int i = 0; i < 16; i++) begin
            b_iss_v = 1'b1; b_iss_rd = 4'(i);
            step();
        end
        idle_b(); b_ra0 = 4'd0;
        #1;
        chk("b_pend_full", 64'(b_pend), 64'd16);
        chk("b_busy0_reg0", 64'(b_busy0), 64'h1);
        b_we = 1'b1; b_wa = 4'd0; b_wd = 64'h5;
        #1;
        chk("b_busy0_nofwd", 64'(b_busy0), 64'h1);
        step();
        idle_b();
        #1;
        chk("b_pend15", 64'(b_pend), 64'd15);
        chk("b_busy0_clr", 64'(b_busy0), 64'h0);
        b_flush = 1'b1;
        step();
        idle_b();
        #1;
        chk("b_flush_pend", 64'(b_pend), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
